// File: rtl/memory_bus_bridge_if.sv
// Interface bundling the core-side request/response signals and the
// Wishbone classic master signals of memory_bus_bridge.
// The master modport is the bridge's view. The slave modport is the
// environment's view, covering both the core and the Wishbone target.
interface memory_bus_bridge_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // core side
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic [BE_WIDTH-1:0]   mem_byte_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_ack;
  logic                  mem_err;

  // Wishbone side
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [BE_WIDTH-1:0]   wb_sel_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    input  mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, mem_wr_data,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output mem_rd_data, mem_ack, mem_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, mem_wr_data,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  mem_rd_data, mem_ack, mem_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/memory_bus_bridge.sv
// memory_bus_bridge: converts a held core read/write request into a single
// Wishbone classic bus cycle, then returns a one-cycle mem_ack to the core.
// The design uses a three-state FSM: IDLE -> BUS -> DONE -> IDLE.
// Every output comes from a register.
// Optional feature: define BUS_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES cycles with no ack and no err. An aborted cycle reports
// mem_err=1.
module memory_bus_bridge #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  memory_bus_bridge_if.master  bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // The timeout counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("memory_bus_bridge: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic                  cyc_r;
  logic                  stb_r;
  logic                  we_r;
  logic [BE_WIDTH-1:0]   sel_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_o_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  ack_r;
  logic                  err_r;

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]           tmo_cnt_r;
`endif

  // FSM with registered outputs: latch the request, run one bus cycle,
  // then produce a single completion pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      we_r      <= 1'b0;
      sel_r     <= '0;
      adr_r     <= '0;
      dat_o_r   <= '0;
      rd_data_r <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_r <= 16'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          if (bus.mem_rd_en || bus.mem_wr_en) begin
            // A simultaneous read and write request is handled as a write.
            we_r    <= bus.mem_wr_en;
            adr_r   <= bus.mem_addr;
            sel_r   <= bus.mem_byte_en;
            dat_o_r <= bus.mem_wr_data;
            cyc_r   <= 1'b1;
            stb_r   <= 1'b1;
            state_r <= ST_BUS;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_r <= 16'd0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_BUS: begin
          if (bus.wb_err_i) begin
            // An error takes priority over an ack in the same cycle.
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            rd_data_r <= '0;
            ack_r     <= 1'b1;
            err_r     <= 1'b1;
            state_r   <= ST_DONE;
          end else if (bus.wb_ack_i) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            if (!we_r) begin
              rd_data_r <= bus.wb_dat_i;
            end else begin
              rd_data_r <= rd_data_r;
            end
            ack_r   <= 1'b1;
            err_r   <= 1'b0;
            state_r <= ST_DONE;
          end else begin
`ifdef BUS_TIMEOUT_EN
            if (tmo_cnt_r == TIMEOUT_LAST) begin
              // The slave stayed silent for TIMEOUT_CYCLES bus cycles.
              cyc_r     <= 1'b0;
              stb_r     <= 1'b0;
              rd_data_r <= '0;
              ack_r     <= 1'b1;
              err_r     <= 1'b1;
              state_r   <= ST_DONE;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + 16'd1;
              state_r   <= ST_BUS;
            end
`else
            state_r <= ST_BUS;
`endif
          end
        end

        ST_DONE: begin
          // Request inputs are ignored here. A request that is still held
          // is picked up in the following IDLE cycle.
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wb_cyc_o    = cyc_r;
  assign bus.wb_stb_o    = stb_r;
  assign bus.wb_we_o     = we_r;
  assign bus.wb_sel_o    = sel_r;
  assign bus.wb_adr_o    = adr_r;
  assign bus.wb_dat_o    = dat_o_r;
  assign bus.mem_rd_data = rd_data_r;
  assign bus.mem_ack     = ack_r;
  assign bus.mem_err     = err_r;
endmodule

// File: tb/tb_memory_bus_bridge.sv
// Directed testbench for memory_bus_bridge using default 64-bit widths.
// Inputs are driven and outputs are sampled on the falling clock edge.
// If BUS_TIMEOUT_EN is defined, the DUT is built with TIMEOUT_CYCLES=4.
module tb_memory_bus_bridge;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  memory_bus_bridge_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus_if ();

  memory_bus_bridge #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clock = ~clock;

  task automatic drive_req(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [7:0] be, input logic [63:0] wd);
    bus_if.mem_rd_en   = rd;
    bus_if.mem_wr_en   = wr;
    bus_if.mem_addr    = addr;
    bus_if.mem_byte_en = be;
    bus_if.mem_wr_data = wd;
  endtask

  task automatic drop_req();
    bus_if.mem_rd_en = 1'b0;
    bus_if.mem_wr_en = 1'b0;
  endtask

  // Call this on a falling edge with the request already driven. It lets
  // the request be sampled, counts the bus cycles, and answers with the
  // given ack/err/data after wait_n silent cycles. It returns on the
  // falling edge where cyc has dropped, or when the cycle cap is reached.
  // It also records the wb outputs seen in the first bus cycle and
  // whether they stayed stable through the cycle.
  task automatic slave_respond(input int wait_n, input logic a, input logic e,
                               input logic [63:0] d, output int ncyc,
                               output logic s_we, output logic [7:0] s_sel,
                               output logic [63:0] s_adr, output logic [63:0] s_dat,
                               output logic stable);
    ncyc = 0; stable = 1'b1; s_we = 1'b0; s_sel = 8'h00; s_adr = 64'h0; s_dat = 64'h0;
    @(posedge clock); @(negedge clock);
    while (bus_if.wb_cyc_o === 1'b1 && ncyc < 200) begin
      ncyc++;
      if (ncyc == 1) begin
        s_we = bus_if.wb_we_o; s_sel = bus_if.wb_sel_o;
        s_adr = bus_if.wb_adr_o; s_dat = bus_if.wb_dat_o;
      end else if (bus_if.wb_we_o !== s_we || bus_if.wb_sel_o !== s_sel ||
                   bus_if.wb_adr_o !== s_adr || bus_if.wb_dat_o !== s_dat ||
                   bus_if.wb_stb_o !== 1'b1) begin
        stable = 1'b0;
      end
      if (ncyc > wait_n) begin
        bus_if.wb_ack_i = a; bus_if.wb_err_i = e; bus_if.wb_dat_i = d;
      end
      @(posedge clock); @(negedge clock);
    end
    bus_if.wb_ack_i = 1'b0; bus_if.wb_err_i = 1'b0; bus_if.wb_dat_i = 64'h0;
  endtask

  task automatic test_reset();
    drive_req(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    bus_if.wb_ack_i = 1'b0; bus_if.wb_err_i = 1'b0; bus_if.wb_dat_i = 64'hFFFF_FFFF_FFFF_FFFF;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (bus_if.mem_rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus_if.mem_rd_data); end
    checks++; if (bus_if.mem_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus_if.mem_ack); end
    checks++; if (bus_if.mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_if.mem_err); end
    checks++; if (bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_stb_o !== 1'b0) begin failures++; $display("FAIL reset_cyc_stb got=%b%b exp=00", bus_if.wb_cyc_o, bus_if.wb_stb_o); end
    checks++; if ({bus_if.wb_we_o, bus_if.wb_sel_o, bus_if.wb_adr_o, bus_if.wb_dat_o} !== 137'h0) begin failures++; $display("FAIL reset_wb_outputs not all zero"); end
    bus_if.wb_dat_i = 64'h0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read();
    int n; logic we, st; logic [7:0] sel; logic [63:0] adr, dat;
    drive_req(1'b1, 1'b0, 64'h1000, 8'hFF, 64'h0);
    slave_respond(3, 1'b1, 1'b0, 64'hDEADBEEFCAFEF00D, n, we, sel, adr, dat, st);
    checks++; if (n !== 4) begin failures++; $display("FAIL read_bus_cycles got=%0d exp=4", n); end
    checks++; if (we !== 1'b0 || adr !== 64'h1000 || sel !== 8'hFF) begin failures++; $display("FAIL read_wb_fields got we=%b adr=%h sel=%h exp we=0 adr=1000 sel=ff", we, adr, sel); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL read_wb_stable got=%b exp=1", st); end
    checks++; if (bus_if.mem_ack !== 1'b1 || bus_if.mem_err !== 1'b0) begin failures++; $display("FAIL read_ack_err got=%b%b exp=10", bus_if.mem_ack, bus_if.mem_err); end
    checks++; if (bus_if.mem_rd_data !== 64'hDEADBEEFCAFEF00D) begin failures++; $display("FAIL read_data got=%h exp=deadbeefcafef00d", bus_if.mem_rd_data); end
    drop_req();
    @(negedge clock);
    checks++; if (bus_if.mem_ack !== 1'b0) begin failures++; $display("FAIL read_ack_single got=%b exp=0", bus_if.mem_ack); end
  endtask

  task automatic test_write();
    drive_req(1'b0, 1'b1, 64'h2004, 8'h0F, 64'h11223344);
    @(posedge clock); @(negedge clock);
    checks++; if (bus_if.wb_cyc_o !== 1'b1 || bus_if.wb_stb_o !== 1'b1 || bus_if.wb_we_o !== 1'b1) begin failures++; $display("FAIL write_cyc_stb_we got=%b%b%b exp=111", bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o); end
    checks++; if (bus_if.wb_sel_o !== 8'h0F || bus_if.wb_dat_o !== 64'h11223344 || bus_if.wb_adr_o !== 64'h2004) begin failures++; $display("FAIL write_fields got sel=%h dat=%h adr=%h", bus_if.wb_sel_o, bus_if.wb_dat_o, bus_if.wb_adr_o); end
    checks++; if (bus_if.mem_ack !== 1'b0) begin failures++; $display("FAIL write_early_ack got=%b exp=0", bus_if.mem_ack); end
    bus_if.wb_ack_i = 1'b1; bus_if.wb_dat_i = 64'h0BAD;
    @(posedge clock); @(negedge clock);
    bus_if.wb_ack_i = 1'b0; bus_if.wb_dat_i = 64'h0;
    checks++; if (bus_if.mem_ack !== 1'b1 || bus_if.mem_err !== 1'b0 || bus_if.wb_cyc_o !== 1'b0) begin failures++; $display("FAIL write_ack_latency got ack=%b err=%b cyc=%b exp 1 0 0", bus_if.mem_ack, bus_if.mem_err, bus_if.wb_cyc_o); end
    checks++; if (bus_if.mem_rd_data !== 64'hDEADBEEFCAFEF00D) begin failures++; $display("FAIL write_rd_data_kept got=%h exp=deadbeefcafef00d", bus_if.mem_rd_data); end
    drop_req();
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int n1, n2; logic we, st; logic [7:0] sel; logic [63:0] adr, dat;
    drive_req(1'b1, 1'b0, 64'h3000, 8'hFF, 64'h0);
    slave_respond(0, 1'b1, 1'b0, 64'h0000_0000_0000_0A01, n1, we, sel, adr, dat, st);
    checks++; if (n1 !== 1 || bus_if.mem_ack !== 1'b1 || bus_if.mem_rd_data !== 64'hA01) begin failures++; $display("FAIL b2b_first got cyc=%0d ack=%b data=%h exp 1 1 a01", n1, bus_if.mem_ack, bus_if.mem_rd_data); end
    @(posedge clock); @(negedge clock);
    checks++; if (bus_if.wb_cyc_o !== 1'b0 || bus_if.mem_ack !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got cyc=%b ack=%b exp 0 0", bus_if.wb_cyc_o, bus_if.mem_ack); end
    slave_respond(0, 1'b1, 1'b0, 64'h0000_0000_0000_0B02, n2, we, sel, adr, dat, st);
    checks++; if (n2 !== 1 || bus_if.mem_ack !== 1'b1 || bus_if.mem_rd_data !== 64'hB02) begin failures++; $display("FAIL b2b_second got cyc=%0d ack=%b data=%h exp 1 1 b02", n2, bus_if.mem_ack, bus_if.mem_rd_data); end
    drop_req();
    n1 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus_if.wb_cyc_o === 1'b1 || bus_if.mem_ack === 1'b1) n1++;
    end
    checks++; if (n1 !== 0) begin failures++; $display("FAIL b2b_no_duplicate got=%0d extra active cycles exp=0", n1); end
  endtask

  task automatic test_err_ack();
    int n; logic we, st; logic [7:0] sel; logic [63:0] adr, dat;
    drive_req(1'b1, 1'b0, 64'h4000, 8'hFF, 64'h0);
    slave_respond(1, 1'b1, 1'b1, 64'h5555_5555_5555_5555, n, we, sel, adr, dat, st);
    checks++; if (n !== 2 || bus_if.mem_ack !== 1'b1 || bus_if.mem_err !== 1'b1) begin failures++; $display("FAIL err_ack got cyc=%0d ack=%b err=%b exp 2 1 1", n, bus_if.mem_ack, bus_if.mem_err); end
    checks++; if (bus_if.mem_rd_data !== 64'h0) begin failures++; $display("FAIL err_rd_data got=%h exp=0", bus_if.mem_rd_data); end
    drop_req();
    @(negedge clock);
    checks++; if (bus_if.mem_err !== 1'b0) begin failures++; $display("FAIL err_clears got=%b exp=0", bus_if.mem_err); end
  endtask

  task automatic test_zero_be_and_both();
    int n; logic we, st; logic [7:0] sel; logic [63:0] adr, dat;
    drive_req(1'b0, 1'b1, 64'h5000, 8'h00, 64'h77);
    slave_respond(0, 1'b1, 1'b0, 64'h0, n, we, sel, adr, dat, st);
    checks++; if (n !== 1 || sel !== 8'h00 || bus_if.mem_ack !== 1'b1) begin failures++; $display("FAIL zero_be got cyc=%0d sel=%h ack=%b exp 1 00 1", n, sel, bus_if.mem_ack); end
    drop_req();
    @(negedge clock);
    drive_req(1'b1, 1'b1, 64'h6000, 8'h3C, 64'h99);
    slave_respond(0, 1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, n, we, sel, adr, dat, st);
    checks++; if (we !== 1'b1 || dat !== 64'h99 || sel !== 8'h3C) begin failures++; $display("FAIL both_is_write got we=%b dat=%h sel=%h exp 1 99 3c", we, dat, sel); end
    checks++; if (bus_if.mem_rd_data !== 64'h0) begin failures++; $display("FAIL both_rd_data_kept got=%h exp=0", bus_if.mem_rd_data); end
    drop_req();
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int n; logic we, st; logic [7:0] sel; logic [63:0] adr, dat;
    drive_req(1'b1, 1'b0, 64'h7000, 8'hFF, 64'h0);
    slave_respond(0, 1'b1, 1'b0, 64'h1234, n, we, sel, adr, dat, st);
    checks++; if (bus_if.mem_rd_data !== 64'h1234) begin failures++; $display("FAIL pre_timeout_read got=%h exp=1234", bus_if.mem_rd_data); end
    drop_req();
    @(negedge clock);
    drive_req(1'b1, 1'b0, 64'h7008, 8'hFF, 64'h0);
    slave_respond(1000, 1'b0, 1'b0, 64'h0, n, we, sel, adr, dat, st);
`ifdef BUS_TIMEOUT_EN
    checks++; if (n !== 4 || bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_stb_o !== 1'b0) begin failures++; $display("FAIL timeout_cycles got=%0d cyc=%b exp 4 0", n, bus_if.wb_cyc_o); end
    checks++; if (bus_if.mem_ack !== 1'b1 || bus_if.mem_err !== 1'b1 || bus_if.mem_rd_data !== 64'h0) begin failures++; $display("FAIL timeout_result got ack=%b err=%b data=%h exp 1 1 0", bus_if.mem_ack, bus_if.mem_err, bus_if.mem_rd_data); end
    drop_req();
    @(negedge clock);
`else
    checks++; if (n !== 200 || bus_if.wb_cyc_o !== 1'b1 || bus_if.mem_ack !== 1'b0) begin failures++; $display("FAIL no_timeout_waits got=%0d cyc=%b ack=%b exp 200 1 0", n, bus_if.wb_cyc_o, bus_if.mem_ack); end
    drop_req();
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
`endif
  endtask

  task automatic test_reset_abort();
    int n; logic we, st; logic [7:0] sel; logic [63:0] adr, dat;
    drive_req(1'b1, 1'b0, 64'h8000, 8'hFF, 64'h0);
    slave_respond(0, 1'b1, 1'b0, 64'h77, n, we, sel, adr, dat, st);
    drop_req();
    @(negedge clock);
    drive_req(1'b1, 1'b0, 64'h8008, 8'hF0, 64'h0);
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    checks++; if (bus_if.wb_cyc_o !== 1'b1) begin failures++; $display("FAIL abort_in_bus got cyc=%b exp=1", bus_if.wb_cyc_o); end
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    checks++; if (bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_stb_o !== 1'b0 || bus_if.mem_ack !== 1'b0 || bus_if.mem_err !== 1'b0) begin failures++; $display("FAIL abort_ctrl got cyc=%b stb=%b ack=%b err=%b exp 0000", bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.mem_ack, bus_if.mem_err); end
    checks++; if (bus_if.mem_rd_data !== 64'h0 || {bus_if.wb_we_o, bus_if.wb_sel_o, bus_if.wb_adr_o, bus_if.wb_dat_o} !== 137'h0) begin failures++; $display("FAIL abort_data got rd=%h adr=%h exp 0 0", bus_if.mem_rd_data, bus_if.wb_adr_o); end
    drop_req();
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus_if.mem_ack === 1'b1 || bus_if.wb_cyc_o === 1'b1) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL abort_no_ack got=%0d active cycles exp=0", n); end
    drive_req(1'b1, 1'b0, 64'h9000, 8'hFF, 64'h0);
    slave_respond(0, 1'b1, 1'b0, 64'hBEEF, n, we, sel, adr, dat, st);
    checks++; if (n !== 1 || bus_if.mem_ack !== 1'b1 || bus_if.mem_rd_data !== 64'hBEEF || adr !== 64'h9000) begin failures++; $display("FAIL after_reset_read got cyc=%0d ack=%b data=%h adr=%h", n, bus_if.mem_ack, bus_if.mem_rd_data, adr); end
    drop_req();
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_err_ack();
    test_zero_be_and_both();
    test_timeout();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
